bus_retry_controller: RTL and testbench
=======================================

Name: bus_retry_controller

Overview:
- Transaction launcher that sits between a requester and the bus.
- Drives start_transaction/complete_transaction into the bus watchdog timer and consumes its timeout_error.
- On timeout: aborts the attempt, waits a fixed backoff, re-issues the same command; after MAX_RETRIES failed retries, reports fatal failure.
- Keeps per-command retry count and a global saturating timeout counter for debug readback.

Parameters:
- ADDR_W, 8, width of command/bus address
- MAX_RETRIES, 3, retries allowed after first attempt (>=0); total attempts = MAX_RETRIES+1
- BACKOFF_CYCLES, 4, cycles bus_req held low between attempts (>=1)
- RC_W, 2, width of retry_count; must hold MAX_RETRIES

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  requester has a command
- cmd_addr  input  ADDR_W  command address
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- bus_req  output  1  bus request, high in ISSUE and WAIT
- bus_addr  output  ADDR_W  latched command address
- bus_ack  input  1  bus completion
- start_transaction  output  1  1-cycle pulse per attempt launch, to watchdog
- complete_transaction  output  1  1-cycle pulse on attempt end (ack or abort), to watchdog
- timeout_error  input  1  from watchdog
- done  output  1  1-cycle pulse, command succeeded
- fail  output  1  1-cycle pulse, retries exhausted
- retry_count  output  RC_W  retries used by current/last command
- total_timeouts  output  16  timeouts accepted since reset, saturating

Behaviour:
- Reset (sync, all outputs): state=IDLE, cmd_ready=1, bus_req=0, bus_addr=0, start_transaction/complete_transaction/done/fail=0, retry_count=0, total_timeouts=0.
- Reset mid-operation aborts with no done/fail/complete pulse.
- FSM states: IDLE, ISSUE, WAIT, BACKOFF. Output timing:
  - bus_req, cmd_ready, start_transaction: decoded from the state register only.
  - done, fail, complete_transaction: registered pulses, high exactly one cycle.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch cmd_addr into bus_addr, clear retry_count, go to ISSUE.
  - cmd_valid while not in IDLE is ignored (no queueing).
- ISSUE (one cycle): bus_req=1, start_transaction=1, then go to WAIT.
- bus_ack and timeout_error are sampled in ISSUE and WAIT only; ignored in IDLE/BACKOFF.
- On bus_ack (in ISSUE or WAIT):
  - Next cycle: complete_transaction=1, done=1, state=IDLE.
  - bus_ack wins over a simultaneous timeout_error: no retry, no counter change.
- On timeout_error without bus_ack:
  - total_timeouts += 1, holding at 0xFFFF.
  - Next cycle: complete_transaction=1 to clear the watchdog, bus_req=0.
  - If retry_count==MAX_RETRIES: fail=1, state=IDLE.
  - Otherwise: retry_count += 1, load backoff counter, state=BACKOFF.
- BACKOFF:
  - bus_req=0 for exactly BACKOFF_CYCLES cycles, then ISSUE with the same bus_addr.
  - Timeout sampled at cycle T: BACKOFF spans T+1..T+BACKOFF_CYCLES; ISSUE at T+BACKOFF_CYCLES+1.
- Latency:
  - cmd accepted cycle 0 -> ISSUE cycle 1.
  - Ack at cycle 1 -> done cycle 2, cmd_ready high cycle 2.
  - Next command can be accepted cycle 2.
- A level-held timeout_error is counted once per attempt, since the state leaves WAIT.
- retry_count and bus_addr hold after done/fail until the next command is accepted.
- total_timeouts is cleared only by reset.

Test Plan:
- Reset, cmd_valid=1 addr=0x3C cycle 0, bus_ack cycle 3 -> start_transaction cycle 1, bus_req high cycles 1-3, done+complete_transaction cycle 4, retry_count=0, bus_addr=0x3C.
- cmd accepted cycle 0, timeout_error cycle 6, bus_ack 2 cycles after re-issue -> bus_req low cycles 7-10, second start_transaction cycle 11, done cycle 14, retry_count=1, total_timeouts=1.
- Defaults, timeout_error on every attempt -> 4 start_transaction pulses, fail pulse once after 4th timeout, no done, retry_count=3, total_timeouts=4, cmd_ready high after fail.
- bus_ack and timeout_error same cycle in WAIT -> done=1, fail=0, no BACKOFF, total_timeouts unchanged, retry_count=0.
- Pulse cmd_valid with new addr during WAIT and BACKOFF -> ignored, bus_addr unchanged. Assert reset during BACKOFF -> next cycle IDLE, all outputs at reset values, no done/fail/complete pulse.
- Force total_timeouts to 0xFFFE, inject 3 timeouts -> reads 0xFFFF and holds; timeout_error in IDLE -> no count change.

Source files
------------

// File: rtl/bus_retry_controller_if.sv
// Requester/bus/watchdog signal bundle for bus_retry_controller.
// The master modport is the controller side; the slave modport is the environment side.
interface bus_retry_controller_if #(
  parameter int ADDR_W = 8,
  parameter int RC_W   = 2
);
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ready;
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ack;
  logic              start_transaction;
  logic              complete_transaction;
  logic              timeout_error;
  logic              done;
  logic              fail;
  logic [RC_W-1:0]   retry_count;
  logic [15:0]       total_timeouts;

  modport master (
    input  cmd_valid, cmd_addr, bus_ack, timeout_error,
    output cmd_ready, bus_req, bus_addr, start_transaction, complete_transaction,
           done, fail, retry_count, total_timeouts
  );

  modport slave (
    output cmd_valid, cmd_addr, bus_ack, timeout_error,
    input  cmd_ready, bus_req, bus_addr, start_transaction, complete_transaction,
           done, fail, retry_count, total_timeouts
  );
endinterface

// File: rtl/bus_retry_controller.sv
// Launches one bus command at a time, retries it after a fixed backoff on watchdog
// timeout, and reports done or fail once the attempts are exhausted.
module bus_retry_controller #(
  parameter int ADDR_W         = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int BACKOFF_CYCLES = 4,
  parameter int RC_W           = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  bus_retry_controller_if.master  bus
);

  localparam int BO_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [15:0]       total_timeouts_q, total_timeouts_d;
  logic [BO_W-1:0]   bo_q, bo_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              cmpl_q, cmpl_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    rc_d             = rc_q;
    total_timeouts_d = total_timeouts_q;
    bo_d             = bo_q;
    done_d           = 1'b0;
    fail_d           = 1'b0;
    cmpl_d           = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rc_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        state_d = WAIT;
        // Ack takes priority: a completed transfer is never retried.
        if (bus.bus_ack) begin
          cmpl_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (bus.timeout_error) begin
          total_timeouts_d = sat_inc16(total_timeouts_q);
          cmpl_d           = 1'b1;
          if (rc_q == RC_W'(MAX_RETRIES)) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rc_d    = rc_q + 1'b1;
            bo_d    = BO_W'(BACKOFF_CYCLES - 1);
            state_d = BACKOFF;
          end
        end
      end
      BACKOFF: begin
        if (bo_q == '0) begin
          state_d = ISSUE;
        end else begin
          bo_d = bo_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      rc_q             <= '0;
      total_timeouts_q <= '0;
      bo_q             <= '0;
      done_q           <= 1'b0;
      fail_q           <= 1'b0;
      cmpl_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      rc_q             <= rc_d;
      total_timeouts_q <= total_timeouts_d;
      bo_q             <= bo_d;
      done_q           <= done_d;
      fail_q           <= fail_d;
      cmpl_q           <= cmpl_d;
    end
  end

  assign bus.cmd_ready            = (state_q == IDLE);
  assign bus.bus_req              = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.start_transaction    = (state_q == ISSUE);
  assign bus.complete_transaction = cmpl_q;
  assign bus.done                 = done_q;
  assign bus.fail                 = fail_q;
  assign bus.bus_addr             = addr_q;
  assign bus.retry_count          = rc_q;
  assign bus.total_timeouts       = total_timeouts_q;

endmodule

// File: tb/tb_bus_retry_controller.sv
// Testbench for bus_retry_controller: directed scenarios plus randomized commands,
// checked against a transaction-level timing model of the retry protocol.
module tb_bus_retry_controller;
  localparam int ADDR_W         = 8;
  localparam int MAX_RETRIES    = 3;
  localparam int BACKOFF_CYCLES = 4;
  localparam int RC_W           = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_retry_controller_if #(.ADDR_W(ADDR_W), .RC_W(RC_W)) bif ();

  bus_retry_controller #(
    .ADDR_W(ADDR_W), .MAX_RETRIES(MAX_RETRIES),
    .BACKOFF_CYCLES(BACKOFF_CYCLES), .RC_W(RC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  int          nchk = 0;
  int          nfail = 0;
  logic [15:0] exp_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] model_sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  // One command. Attempts 0..n_to-1 time out; later attempts are acked.
  // d_first/d_rest: cycles from the ISSUE cycle to the response (-1 = random).
  task automatic run_cmd(input logic [7:0] addr, input int n_to, input int d_first,
                         input int d_rest, input bit both);
    int d;
    bit fin;
    int exp_rc;
    fin = 1'b0;
    chk("cmd_ready_idle", bif.cmd_ready, 1);
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = addr;
    tick();
    for (int k = 0; k <= MAX_RETRIES && !fin; k++) begin
      d = (k == 0) ? d_first : d_rest;
      if (d < 0) d = $urandom_range(0, 4);
      for (int i = 0; i <= d; i++) begin
        chk("start_pulse", bif.start_transaction, (i == 0));
        chk("bus_req_att", bif.bus_req, 1);
        chk("bus_addr_att", bif.bus_addr, addr);
        chk("cmd_ready_busy", bif.cmd_ready, 0);
        bif.cmd_valid     = $urandom_range(0, 1);
        bif.cmd_addr      = addr ^ 8'hA5;
        bif.bus_ack       = (i == d) && (k >= n_to);
        bif.timeout_error = (i == d) && ((k < n_to) || both);
        tick();
      end
      bif.bus_ack       = 1'b0;
      bif.timeout_error = 1'b0;
      chk("complete_pulse", bif.complete_transaction, 1);
      chk("bus_req_end", bif.bus_req, 0);
      if (k >= n_to) begin
        bif.cmd_valid = 1'b0;
        chk("done_ack", bif.done, 1);
        chk("fail_ack", bif.fail, 0);
        fin = 1'b1;
      end else begin
        exp_total = model_sat(exp_total);
        if (k == MAX_RETRIES) begin
          bif.cmd_valid = 1'b0;
          chk("fail_exhaust", bif.fail, 1);
          chk("done_exhaust", bif.done, 0);
          fin = 1'b1;
        end else begin
          chk("done_retry", bif.done, 0);
          chk("fail_retry", bif.fail, 0);
          for (int i = 0; i < BACKOFF_CYCLES; i++) begin
            chk("bus_req_backoff", bif.bus_req, 0);
            chk("start_backoff", bif.start_transaction, 0);
            chk("rc_backoff", bif.retry_count, k + 1);
            bif.cmd_valid     = $urandom_range(0, 1);
            bif.cmd_addr      = addr ^ 8'h3C;
            bif.bus_ack       = $urandom_range(0, 1);
            bif.timeout_error = $urandom_range(0, 1);
            tick();
          end
        end
      end
    end
    exp_rc = (n_to > MAX_RETRIES) ? MAX_RETRIES : n_to;
    chk("cmd_ready_after", bif.cmd_ready, 1);
    chk("retry_count", bif.retry_count, exp_rc);
    chk("total_timeouts", bif.total_timeouts, exp_total);
    chk("bus_addr_hold", bif.bus_addr, addr);
    tick();
    chk("done_one_cycle", bif.done, 0);
    chk("fail_one_cycle", bif.fail, 0);
    chk("complete_one_cycle", bif.complete_transaction, 0);
    chk("retry_count_hold", bif.retry_count, exp_rc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset             = 1'b1;
    bif.cmd_valid     = 1'b0;
    bif.cmd_addr      = '0;
    bif.bus_ack       = 1'b0;
    bif.timeout_error = 1'b0;
    exp_total         = 16'd0;
    tick();
    tick();
    chk("rst_cmd_ready", bif.cmd_ready, 1);
    chk("rst_bus_req", bif.bus_req, 0);
    chk("rst_bus_addr", bif.bus_addr, 0);
    chk("rst_start", bif.start_transaction, 0);
    chk("rst_complete", bif.complete_transaction, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_fail", bif.fail, 0);
    chk("rst_rc", bif.retry_count, 0);
    chk("rst_total", bif.total_timeouts, 0);
    reset = 1'b0;
    tick();

    run_cmd(8'h3C, 0, 2, 0, 1'b0);
    run_cmd(8'h81, 1, 5, 2, 1'b0);
    run_cmd(8'hC3, 4, -1, -1, 1'b0);
    run_cmd(8'h5A, 0, 3, 0, 1'b1);
    run_cmd(8'h11, 0, 0, 0, 1'b0);
    repeat (20) run_cmd(8'($urandom), $urandom_range(0, 5), -1, -1, 1'($urandom_range(0, 1)));

    // Reset in the middle of BACKOFF.
    bif.cmd_valid = 1'b1;
    bif.cmd_addr  = 8'h55;
    tick();
    bif.cmd_valid     = 1'b0;
    bif.timeout_error = 1'b1;
    tick();
    bif.timeout_error = 1'b0;
    tick();
    chk("pre_rst_bus_req", bif.bus_req, 0);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    exp_total = 16'd0;
    chk("mid_rst_cmd_ready", bif.cmd_ready, 1);
    chk("mid_rst_bus_addr", bif.bus_addr, 0);
    chk("mid_rst_rc", bif.retry_count, 0);
    chk("mid_rst_total", bif.total_timeouts, 0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_bus_req", bif.bus_req, 0);
      chk("mid_rst_pulses",
          {bif.start_transaction, bif.complete_transaction, bif.done, bif.fail}, 0);
      tick();
    end

    // Responses while IDLE are ignored.
    run_cmd(8'h77, 2, -1, -1, 1'b0);
    bif.timeout_error = 1'b1;
    bif.bus_ack       = 1'b1;
    repeat (3) tick();
    bif.timeout_error = 1'b0;
    bif.bus_ack       = 1'b0;
    chk("idle_to_total", bif.total_timeouts, exp_total);
    chk("idle_to_done", bif.done, 0);
    chk("idle_to_cmd_ready", bif.cmd_ready, 1);

    // Saturation of the global timeout counter.
    force dut.total_timeouts_q = 16'hFFFE;
    #1;
    release dut.total_timeouts_q;
    exp_total = 16'hFFFE;
    chk("sat_preload", bif.total_timeouts, 16'hFFFE);
    run_cmd(8'hE1, 3, -1, -1, 1'b0);
    chk("sat_value", bif.total_timeouts, 16'hFFFF);
    run_cmd(8'hE2, 4, -1, -1, 1'b0);
    chk("sat_hold", bif.total_timeouts, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
